// File: rtl/clock_time_ctrl_if.sv
// Button inputs and BCD time/display outputs of the clock timekeeping controller.
// master = button/display side, slave = clock_time_ctrl.
interface clock_time_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] sec_L, sec_H;
  logic [3:0] min_L, min_H;
  logic [3:0] hr_L,  hr_H;
  logic [1:0] state;
  logic       blink;
  logic       sec_tick;
  logic       day_carry;

  modport master (
    output btn_mode, btn_inc,
    input  sec_L, sec_H, min_L, min_H, hr_L, hr_H,
    input  state, blink, sec_tick, day_carry
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec_L, sec_H, min_L, min_H, hr_L, hr_H,
    output state, blink, sec_tick, day_carry
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// One-second prescaler, BCD hh:mm:ss chain with day rollover, and the
// RUN/SET_HR/SET_MIN/SET_SEC editing state machine driven by two buttons.
module clock_time_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input logic clk,
  input logic clr,
  clock_time_ctrl_if.slave bus
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [3:0]    sec_l, sec_h, min_l, min_h, hr_l, hr_h;
  logic [3:0]    sec_l_d, sec_h_d, min_l_d, min_h_d, hr_l_d, hr_h_d;
  logic          day_d;
  logic          sec_tick_q, day_carry_q;
  logic          run_tick, edit_inc;
  logic [8:0]    s_inc, m_inc, h_inc;

  // Two-digit BCD increment: returns {wrapped, hi, lo}; wraps to 00 after {hi_max, lo_max}.
  function automatic logic [8:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo,
                                         input logic [3:0] hi_max, input logic [3:0] lo_max);
    if (hi == hi_max && lo == lo_max) bcd_inc = 9'h100;
    else if (lo == 4'd9)              bcd_inc = {1'b0, hi + 4'd1, 4'd0};
    else                              bcd_inc = {1'b0, hi, lo + 4'd1};
  endfunction

  assign s_inc = bcd_inc(sec_h, sec_l, 4'd5, 4'd9);
  assign m_inc = bcd_inc(min_h, min_l, 4'd5, 4'd9);
  assign h_inc = bcd_inc(hr_h,  hr_l,  4'd2, 4'd3);

  // Timekeeping advances only in RUN; edits are dropped when a mode pulse coincides.
  assign run_tick = (state_q == RUN) && (presc == LAST);
  assign edit_inc = (state_q != RUN) && bus.btn_inc && !bus.btn_mode;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (bus.btn_mode) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see earlier results in the same pass.
    {sec_h_d, sec_l_d} = {sec_h, sec_l};
    {min_h_d, min_l_d} = {min_h, min_l};
    {hr_h_d,  hr_l_d}  = {hr_h,  hr_l};
    day_d              = 1'b0;
    if (run_tick) begin
      {sec_h_d, sec_l_d} = s_inc[7:0];
      if (s_inc[8]) begin
        {min_h_d, min_l_d} = m_inc[7:0];
        if (m_inc[8]) begin
          {hr_h_d, hr_l_d} = h_inc[7:0];
          day_d            = h_inc[8];
        end
      end
    end else if (edit_inc) begin
      case (state_q)
        SET_HR:  {hr_h_d,  hr_l_d}  = h_inc[7:0];
        SET_MIN: {min_h_d, min_l_d} = m_inc[7:0];
        SET_SEC: {sec_h_d, sec_l_d} = s_inc[7:0];
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= RUN;
      presc       <= '0;
      sec_l       <= '0;
      sec_h       <= '0;
      min_l       <= '0;
      min_h       <= '0;
      hr_l        <= '0;
      hr_h        <= '0;
      sec_tick_q  <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Leaving SET_SEC restarts the second so the first tick is a full period away.
      if ((state_q == SET_SEC && bus.btn_mode) || presc == LAST) presc <= '0;
      else                                                      presc <= presc + 1'b1;
      sec_l       <= sec_l_d;
      sec_h       <= sec_h_d;
      min_l       <= min_l_d;
      min_h       <= min_h_d;
      hr_l        <= hr_l_d;
      hr_h        <= hr_h_d;
      sec_tick_q  <= run_tick;
      day_carry_q <= day_d;
    end
  end

  assign bus.sec_L     = sec_l;
  assign bus.sec_H     = sec_h;
  assign bus.min_L     = min_l;
  assign bus.min_H     = min_h;
  assign bus.hr_L      = hr_l;
  assign bus.hr_H      = hr_h;
  assign bus.state     = state_q;
  assign bus.blink     = (state_q != RUN) && (presc >= HALF);
  assign bus.sec_tick  = sec_tick_q;
  assign bus.day_carry = day_carry_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: a seconds-of-day reference model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_clock_time_ctrl;

  localparam int DIV = 4;

  typedef struct packed {
    logic [3:0] hr_H, hr_L, min_H, min_L, sec_H, sec_L;
    logic [1:0] state;
    logic       blink, sec_tick, day_carry;
  } obs_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  clock_time_ctrl_if bus ();

  clock_time_ctrl #(.TICK_DIV(DIV)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  obs_t exp_q[$];

  // Reference state: time as seconds since midnight, mode 0..3, prescaler count.
  int m_tsec, m_mode, m_presc;

  function automatic string fmt(input obs_t o);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d st=%0d bl=%0b tk=%0b dc=%0b",
                     o.hr_H, o.hr_L, o.min_H, o.min_L, o.sec_H, o.sec_L,
                     o.state, o.blink, o.sec_tick, o.day_carry);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.hr_H = bus.hr_H;   o.hr_L = bus.hr_L;
    o.min_H = bus.min_H; o.min_L = bus.min_L;
    o.sec_H = bus.sec_H; o.sec_L = bus.sec_L;
    o.state = bus.state; o.blink = bus.blink;
    o.sec_tick = bus.sec_tick; o.day_carry = bus.day_carry;
    return o;
  endfunction

  function automatic obs_t model_obs(input logic tk, input logic dc);
    obs_t o;
    int h, mi, s;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    o.hr_H  = 4'(h / 10);  o.hr_L  = 4'(h % 10);
    o.min_H = 4'(mi / 10); o.min_L = 4'(mi % 10);
    o.sec_H = 4'(s / 10);  o.sec_L = 4'(s % 10);
    o.state = 2'(m_mode);
    o.blink = (m_mode != 0) && (m_presc >= DIV / 2);
    o.sec_tick  = tk;
    o.day_carry = dc;
    return o;
  endfunction

  function automatic void model_reset();
    m_tsec  = 0;
    m_mode  = 0;
    m_presc = 0;
  endfunction

  // Advance the model by one clock edge with the given button inputs.
  function automatic obs_t model_edge(input logic m, input logic i);
    int   h, mi, s;
    logic tk, dc;
    tk = 1'b0;
    dc = 1'b0;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    if (m_mode == 0) begin
      if (m_presc == DIV - 1) begin
        m_tsec = (m_tsec + 1) % 86400;
        tk = 1'b1;
        dc = (m_tsec == 0);
      end
    end else if (i && !m) begin
      case (m_mode)
        1:       h  = (h + 1) % 24;
        2:       mi = (mi + 1) % 60;
        default: s  = (s + 1) % 60;
      endcase
      m_tsec = h * 3600 + mi * 60 + s;
    end
    m_presc = (m_mode == 3 && m) ? 0 : (m_presc + 1) % DIV;
    if (m) m_mode = (m_mode + 1) % 4;
    return model_obs(tk, dc);
  endfunction

  // Drive one cycle of buttons; the prediction is queued once the edge has happened.
  task automatic step(input logic m, input logic i);
    obs_t e;
    bus.btn_mode = m;
    bus.btn_inc  = i;
    e = model_edge(m, i);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic run_idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  // Assert clr between edges and check that outputs clear before any edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2;
    clr = 1'b1;
    model_reset();
    #1;
    check("async_reset", sample(), model_obs(1'b0, 1'b0));
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle_%0d", cyc), sample(), e);
      end
    end
  end

  initial begin : stimulus
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    model_reset();
    #1;
    check("reset_state", sample(), model_obs(1'b0, 1'b0));
    @(negedge clk);
    #1;
    clr = 1'b0;

    // Tick chain from reset through 00:01:00 up to 01:00:00.
    run_idle(3600 * DIV + 2);

    // Set 23:59:59 via set mode, then watch the day rollover.
    step(1'b1, 1'b0);
    while (m_tsec / 3600 != 23) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    while ((m_tsec / 60) % 60 != 59) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    while (m_tsec % 60 != 59) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    run_idle(3 * DIV);

    // Full wraps of hours and minutes, then mode+inc together, then inc in RUN.
    step(1'b1, 1'b0);
    repeat (24) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b1);
    run_idle(5);
    step(1'b1, 1'b1);
    run_idle(3);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1);
    run_idle(2 * DIV);

    // Mode pulse coinciding with a RUN tick: tick commits, state moves on.
    while (m_presc != DIV - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run_idle(DIV + 1);

    // Reset in the middle of SET_MIN with minutes at 37.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    while ((m_tsec / 60) % 60 != 37) step(1'b0, 1'b1);
    run_idle(3);
    do_reset();
    run_idle(3 * DIV);

    // Randomised buttons with occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
